// File: rtl/pipeline_control.sv
// Control unit: decodes D, carries control fields through E and W, resolves branches, sequences the BNN path.
// Latency: decode is combinational; fields reach E one cycle later and W two cycles later (BNN ops: BNN_LATENCY+1).
// Backpressure: a BNN op stalls F/D for BNN_LATENCY-1 cycles while E holds; a taken branch flushes D and bubbles E.
// Optional feature macro: PIPE_PERF_CNT_EN (retired-instruction counter; RetiredCount reads 0 when undefined).
module pipeline_control #(
   parameter int BNN_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] InstrD,
   input  logic        zero,
   output logic [1:0]  ImmFormatD,
   output logic        RegWE_E,
   output logic        RegWE_W,
   output logic        OpBSrcE,
   output logic        ExPathE,
   output logic [2:0]  ALUFuncE,
   output logic        PCSrcE,
   output logic        StallFD,
   output logic        FlushD,
   output logic        IllegalD,
   output logic [31:0] RetiredCount
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_CUST0  = 7'b0001011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   // valid marks a real (non-bubble) instruction; brInv is funct3[0] (BNE inverts the zero test)
   typedef struct packed {
      logic       valid;
      logic       regWE;
      logic       opBSrc;
      logic       exPath;
      logic       branch;
      logic       brInv;
      logic [2:0] aluFunc;
   } ctrl_t;

   typedef enum logic {IDLE, BUSY} bnnState_t;

   // {unsupported, aluFunc} for the register/immediate ALU funct3 field
   function automatic logic [3:0] mapF3(input logic [2:0] f3);
      case (f3)
         3'b000:  mapF3 = {1'b0, 3'b000};
         3'b001:  mapF3 = {1'b0, 3'b110};
         3'b010:  mapF3 = {1'b0, 3'b101};
         3'b100:  mapF3 = {1'b0, 3'b100};
         3'b101:  mapF3 = {1'b0, 3'b111};
         3'b110:  mapF3 = {1'b0, 3'b011};
         3'b111:  mapF3 = {1'b0, 3'b010};
         default: mapF3 = {1'b1, 3'b000};
      endcase
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [3:0] f3Map;
   ctrl_t      ctrlD;
   ctrl_t      ctrlE;
   logic       validW;
   bnnState_t  state, stateNext;
   logic [3:0] cnt, cntNext;
   logic       unusedInstrBits;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign f3Map  = mapF3(funct3);
   // register specifiers and immediates are datapath concerns, not control
   assign unusedInstrBits = ^{InstrD[24:15], InstrD[11:7]};

   // Decode of the D-stage instruction; unsupported encodings become a NOP with IllegalD set
   always_comb begin
      ctrlD      = '0;
      ImmFormatD = 2'b00;
      IllegalD   = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (f3Map[3] || !(funct7 == 7'b0000000 || funct7 == 7'b0100000) ||
                (funct7[5] && funct3 != 3'b000)) begin
               IllegalD = 1'b1;
            end else begin
               ctrlD.valid   = 1'b1;
               ctrlD.regWE   = 1'b1;
               ctrlD.aluFunc = funct7[5] ? ALU_SUB : f3Map[2:0];
            end
         end
         OPC_OPIMM: begin
            // only the shift-right encoding looks at funct7 (arithmetic shift is unsupported)
            if (f3Map[3] || (funct3 == 3'b101 && funct7[5])) begin
               IllegalD = 1'b1;
            end else begin
               ctrlD.valid   = 1'b1;
               ctrlD.regWE   = 1'b1;
               ctrlD.opBSrc  = 1'b1;
               ctrlD.aluFunc = f3Map[2:0];
            end
         end
         OPC_LOAD, OPC_JALR: begin
            ctrlD.valid  = 1'b1;
            ctrlD.regWE  = 1'b1;
            ctrlD.opBSrc = 1'b1;
         end
         OPC_STORE: begin
            ImmFormatD   = 2'b01;
            ctrlD.valid  = 1'b1;
            ctrlD.opBSrc = 1'b1;
         end
         OPC_BRANCH: begin
            if (funct3[2:1] != 2'b00) begin
               IllegalD = 1'b1;
            end else begin
               ImmFormatD    = 2'b10;
               ctrlD.valid   = 1'b1;
               ctrlD.branch  = 1'b1;
               ctrlD.brInv   = funct3[0];
               ctrlD.aluFunc = ALU_SUB;
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            ImmFormatD   = 2'b11;
            ctrlD.valid  = 1'b1;
            ctrlD.regWE  = 1'b1;
            ctrlD.opBSrc = 1'b1;
         end
         OPC_CUST0: begin
            ctrlD.valid   = 1'b1;
            ctrlD.regWE   = 1'b1;
            ctrlD.exPath  = 1'b1;
            ctrlD.aluFunc = ALU_ADD;
         end
         default: IllegalD = 1'b1;
      endcase
   end

   assign PCSrcE = ctrlE.branch & (zero ^ ctrlE.brInv);
   assign FlushD = PCSrcE;

   // D->E register: a taken branch inserts a bubble, a BNN stall holds the current op
   always_ff @(posedge clk) begin
      if (reset)
         ctrlE <= '0;
      else if (PCSrcE)
         ctrlE <= '0;
      else if (!StallFD)
         ctrlE <= ctrlD;
   end

   // E->W register: nothing retires while the BNN result is still pending
   always_ff @(posedge clk) begin
      if (reset) begin
         RegWE_W <= 1'b0;
         validW  <= 1'b0;
      end else if (StallFD) begin
         RegWE_W <= 1'b0;
         validW  <= 1'b0;
      end else begin
         RegWE_W <= ctrlE.regWE;
         validW  <= ctrlE.valid;
      end
   end

   // BNN sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // BNN sequencer: the op's first E cycle (IDLE) and every BUSY cycle but the last stall the front end,
   // so the op occupies E for exactly BNN_LATENCY cycles and retires on the BUSY exit edge
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      StallFD   = 1'b0;
      case (state)
         IDLE: begin
            if (ctrlE.exPath && (BNN_LATENCY > 1)) begin
               StallFD   = 1'b1;
               stateNext = BUSY;
               cntNext   = 4'(BNN_LATENCY - 1);
            end
         end
         BUSY: begin
            cntNext = cnt - 4'd1;
            if (cnt == 4'd1)
               stateNext = IDLE;
            else
               StallFD = 1'b1;
         end
         default: begin
            stateNext = IDLE;
            cntNext   = 4'd0;
         end
      endcase
   end

   assign RegWE_E  = ctrlE.regWE;
   assign OpBSrcE  = ctrlE.opBSrc;
   assign ExPathE  = ctrlE.exPath;
   assign ALUFuncE = ctrlE.aluFunc;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] retiredCnt;

   // Count every real instruction leaving W, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset)
         retiredCnt <= 32'd0;
      else if (validW)
         retiredCnt <= retiredCnt + 32'd1;
   end

   assign RetiredCount = retiredCnt;
`else
   logic unusedValidW;
   assign unusedValidW = validW;
   assign RetiredCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

   localparam int LAT = 3;

   localparam bit [31:0] I_ADDI = 32'h00700093;
   localparam bit [31:0] I_NOP  = 32'h00000013;
   localparam bit [31:0] I_SUB  = 32'h40208233;
   localparam bit [31:0] I_ADD  = 32'h002081B3;
   localparam bit [31:0] I_BEQ  = 32'h00000463;
   localparam bit [31:0] I_CUST = 32'h0020808B;
   localparam bit [31:0] I_ILL  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] InstrD;
   logic        zero;

   logic [1:0]  ImmFormatD;
   logic        RegWE_E, RegWE_W, OpBSrcE, ExPathE, PCSrcE, StallFD, FlushD, IllegalD;
   logic [2:0]  ALUFuncE;
   logic [31:0] RetiredCount;

   logic [1:0]  s1Imm;
   logic        s1WeE, s1WeW, s1OpB, s1Ex, s1Pc, s1Stall, s1Flush, s1Ill;
   logic [2:0]  s1Alu;
   logic [31:0] s1Ret;

   pipeline_control #(.BNN_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .zero(zero),
      .ImmFormatD(ImmFormatD), .RegWE_E(RegWE_E), .RegWE_W(RegWE_W), .OpBSrcE(OpBSrcE),
      .ExPathE(ExPathE), .ALUFuncE(ALUFuncE), .PCSrcE(PCSrcE), .StallFD(StallFD),
      .FlushD(FlushD), .IllegalD(IllegalD), .RetiredCount(RetiredCount)
   );

   pipeline_control #(.BNN_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .InstrD(InstrD), .zero(zero),
      .ImmFormatD(s1Imm), .RegWE_E(s1WeE), .RegWE_W(s1WeW), .OpBSrcE(s1OpB),
      .ExPathE(s1Ex), .ALUFuncE(s1Alu), .PCSrcE(s1Pc), .StallFD(s1Stall),
      .FlushD(s1Flush), .IllegalD(s1Ill), .RetiredCount(s1Ret)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model (instruction-level pipeline slots) ----------------
   typedef struct packed {
      bit       v;
      bit       we;
      bit       opb;
      bit       ex;
      bit       br;
      bit       f3b0;
      bit [2:0] alu;
   } op_t;

   typedef struct packed {
      bit       ill;
      bit [1:0] imm;
      op_t      op;
   } dec_t;

   bit [2:0] f3Alu [8] = '{3'b000, 3'b110, 3'b101, 3'b000, 3'b100, 3'b111, 3'b011, 3'b010};

   op_t       mE;
   bit        mWe, mWv;
   int        mOcc;
   bit [31:0] mRet;
   bit        modelOn = 1'b0;

   function automatic dec_t refDecode(input bit [31:0] ins);
      dec_t d;
      bit [6:0] opc = ins[6:0];
      bit [2:0] f3  = ins[14:12];
      bit [6:0] f7  = ins[31:25];
      d = '0;
      case (opc)
         7'b0110011:
            if (f3 == 3'b011 || !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 != 3'b000)) d.ill = 1;
            else begin d.op.v = 1; d.op.we = 1; d.op.alu = (f7 == 7'h20) ? 3'b001 : f3Alu[f3]; end
         7'b0010011:
            if (f3 == 3'b011 || (f3 == 3'b101 && f7[5])) d.ill = 1;
            else begin d.op.v = 1; d.op.we = 1; d.op.opb = 1; d.op.alu = f3Alu[f3]; end
         7'b0000011, 7'b1100111: begin d.op.v = 1; d.op.we = 1; d.op.opb = 1; end
         7'b0100011: begin d.imm = 2'b01; d.op.v = 1; d.op.opb = 1; end
         7'b1100011:
            if (f3 > 3'b001) d.ill = 1;
            else begin d.imm = 2'b10; d.op.v = 1; d.op.br = 1; d.op.f3b0 = f3[0]; d.op.alu = 3'b001; end
         7'b0110111, 7'b0010111: begin d.imm = 2'b11; d.op.v = 1; d.op.we = 1; d.op.opb = 1; end
         7'b0001011: begin d.op.v = 1; d.op.we = 1; d.op.ex = 1; end
         default: d.ill = 1;
      endcase
      return d;
   endfunction

   function automatic bit [12:0] mk(bit [1:0] imm, bit ill, bit weE, bit weW, bit opb, bit ex,
                                    bit [2:0] alu, bit pc, bit st, bit fl);
      return {imm, ill, weE, weW, opb, ex, alu, pc, st, fl};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive at negedge, check combinational/registered outputs, then advance the model at posedge
   task automatic tick(input bit rst, input bit [31:0] ins, input bit z,
                       input bit useRow, input bit [12:0] rowExp, input string nm);
      dec_t      dd;
      bit        pc, st;
      bit [31:0] expRet;
      logic [12:0] act;
      @(negedge clk);
      reset = rst; InstrD = ins; zero = z;
      #1;
      act = {ImmFormatD, IllegalD, RegWE_E, RegWE_W, OpBSrcE, ExPathE, ALUFuncE, PCSrcE, StallFD, FlushD};
      dd = refDecode(ins);
      pc = mE.br & (z ^ mE.f3b0);
      st = mE.ex && (LAT > 1) && (mOcc > 1);
      if (modelOn) begin
         chk({nm, "/model"}, 32'(act),
             32'(mk(dd.imm, dd.ill, mE.we, mWe, mE.opb, mE.ex, mE.alu, pc, st, pc)));
`ifdef PIPE_PERF_CNT_EN
         expRet = mRet;
`else
         expRet = 32'd0;
`endif
         chk({nm, "/retired"}, RetiredCount, expRet);
      end
      if (useRow) chk(nm, 32'(act), 32'(rowExp));
      chk({nm, "/lat1_nostall"}, 32'(s1Stall), 32'd0);
      @(posedge clk);
      if (rst) begin
         mE = '0; mWe = 0; mWv = 0; mOcc = 0; mRet = 0; modelOn = 1'b1;
      end else begin
         mRet = mRet + 32'(mWv);
         mWe  = st ? 1'b0 : mE.we;
         mWv  = st ? 1'b0 : mE.v;
         if (pc) begin mE = '0; mOcc = 0; end
         else if (st) mOcc--;
         else begin mE = dd.op; mOcc = LAT; end
      end
   endtask

   typedef struct {
      bit [31:0] instr;
      bit        z;
      bit [12:0] exp;
   } vec_t;

   vec_t vecs [18];

   bit [31:0] pool [14] = '{I_ADDI, I_NOP, I_SUB, I_ADD, I_BEQ, 32'h00001463, I_CUST, I_ILL,
                            32'h0000A083, 32'h0020A023, 32'h000010B7, 32'h0000006F,
                            32'h00004463, 32'h0020F233};

   initial begin
      reset = 1'b1; InstrD = I_NOP; zero = 1'b0;
      mE = '0; mWe = 0; mWv = 0; mOcc = 0; mRet = 0;

      //             instr   z   imm  ill weE weW opb ex  alu     pc st fl
      vecs[0]  = '{I_ADDI, 0, mk(2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0)};
      vecs[1]  = '{I_NOP,  0, mk(2'b00, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0)};
      vecs[2]  = '{I_SUB,  0, mk(2'b00, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0)};
      vecs[3]  = '{I_ADD,  0, mk(2'b00, 0, 1, 1, 0, 0, 3'b001, 0, 0, 0)};
      vecs[4]  = '{I_BEQ,  0, mk(2'b10, 0, 1, 1, 0, 0, 3'b000, 0, 0, 0)};
      vecs[5]  = '{I_NOP,  1, mk(2'b00, 0, 0, 1, 0, 0, 3'b001, 1, 0, 1)};
      vecs[6]  = '{I_NOP,  0, mk(2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0)};
      vecs[7]  = '{I_BEQ,  0, mk(2'b10, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0)};
      vecs[8]  = '{I_NOP,  0, mk(2'b00, 0, 0, 1, 0, 0, 3'b001, 0, 0, 0)};
      vecs[9]  = '{I_CUST, 0, mk(2'b00, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0)};
      vecs[10] = '{I_ADDI, 0, mk(2'b00, 0, 1, 1, 0, 1, 3'b000, 0, 1, 0)};
      vecs[11] = '{I_ADDI, 0, mk(2'b00, 0, 1, 0, 0, 1, 3'b000, 0, 1, 0)};
      vecs[12] = '{I_ADDI, 0, mk(2'b00, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0)};
      vecs[13] = '{I_NOP,  0, mk(2'b00, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0)};
      vecs[14] = '{I_NOP,  0, mk(2'b00, 0, 1, 1, 1, 0, 3'b000, 0, 0, 0)};
      vecs[15] = '{I_ILL,  0, mk(2'b00, 1, 1, 1, 1, 0, 3'b000, 0, 0, 0)};
      vecs[16] = '{I_NOP,  0, mk(2'b00, 0, 0, 1, 0, 0, 3'b000, 0, 0, 0)};
      vecs[17] = '{I_NOP,  0, mk(2'b00, 0, 1, 0, 1, 0, 3'b000, 0, 0, 0)};

      tick(1, I_NOP, 0, 0, '0, "reset0");
      tick(1, I_NOP, 0, 0, '0, "reset1");
      #1;
      chk("reset_state", {26'd0, RegWE_E, RegWE_W, StallFD, PCSrcE, ExPathE, OpBSrcE}, 32'd0);
      chk("reset_alu", 32'(ALUFuncE), 32'd0);

      for (int i = 0; i < 18; i++) tick(0, vecs[i].instr, vecs[i].z, 1, vecs[i].exp, $sformatf("vec%0d", i));

      // BNN op with latency 1 retires straight through
      tick(1, I_NOP, 0, 0, '0, "l1_rst");
      tick(0, I_CUST, 0, 0, '0, "l1_d");
      tick(0, I_NOP, 0, 0, '0, "l1_e");
      #1 chk("lat1_ex_in_e_then_w", {s1WeW, s1Ex}, {30'd0, 2'b10});

      // reset on the first BUSY cycle
      tick(0, I_CUST, 0, 0, '0, "rb_d");
      tick(0, I_NOP, 0, 0, '0, "rb_start");
      tick(1, I_NOP, 0, 0, '0, "rb_busy_reset");
      #1;
      chk("busy_reset_stall", 32'(StallFD), 32'd0);
      chk("busy_reset_weE",   32'(RegWE_E), 32'd0);
      chk("busy_reset_weW",   32'(RegWE_W), 32'd0);
      chk("busy_reset_ret",   RetiredCount, 32'd0);

      // retired counting: illegal does not count, three ADDIs do
      tick(0, I_ILL, 0, 0, '0, "rc0");
      tick(0, I_ADDI, 0, 0, '0, "rc1");
      tick(0, I_ADDI, 0, 0, '0, "rc2");
      #1 chk("retired_after_illegal", RetiredCount, 32'd0);
      tick(0, I_ADDI, 0, 0, '0, "rc3");
      tick(0, I_ILL, 0, 0, '0, "rc4");
      tick(0, I_ILL, 0, 0, '0, "rc5");
`ifdef PIPE_PERF_CNT_EN
      #1 chk("retired_three_addi", RetiredCount, 32'd3);
`else
      #1 chk("retired_tied_zero", RetiredCount, 32'd0);
`endif

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 49) == 0), pool[$urandom_range(0, 13)], 1'($urandom_range(0, 1)),
              0, '0, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Control unit for the pipelined RV32 datapath. Decodes the instruction held in the Decode stage into datapath control fields, then carries those fields through the E and W pipeline registers. Resolves branches in E using the datapath `zero` flag and drives the flush outputs. Sequences the multi-cycle BNN execute path by stalling the front end until the BNN result is ready.

Parameters:
- BNN_LATENCY, 2, cycles an ExPath=1 op occupies E (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- InstrD  in  32  instruction in Decode stage.
- zero  in  1  ALU zero flag from E stage.
- ImmFormatD  out  2  immediate format: 00 I, 01 S, 10 B, 11 U.
- RegWE_E  out  1  register write enable, E copy.
- RegWE_W  out  1  register write enable, W copy (drives regfile write).
- OpBSrcE  out  1  0 = rs2, 1 = immediate.
- ExPathE  out  1  0 = ALU, 1 = BNN unit.
- ALUFuncE  out  3  ALU operation code.
- PCSrcE  out  1  1 = branch taken, select branch target.
- StallFD  out  1  hold PC and F/D register.
- FlushD  out  1  clear F/D register (insert NOP).
- IllegalD  out  1  unsupported opcode/funct in D.
- RetiredCount  out  32  retired instruction count.

Behaviour:
- Decode in D is combinational.
  - ImmFormatD: 00 for OP-IMM, LOAD, JALR; 01 STORE; 10 BRANCH; 11 LUI/AUIPC.
- ALUFunc encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
  - OP (0110011): funct7[5]=1 with funct3=000 gives SUB.
  - OP-IMM (0010011): always uses funct3 mapping; funct7 ignored except for shifts.
- BRANCH: ALUFunc SUB, OpBSrc 0, RegWE 0. Only BEQ (funct3 000) and BNE (001) are legal.
- Custom-0 (0001011): ExPath 1, OpBSrc 0, RegWE 1.
- Any other opcode asserts IllegalD and decodes as a NOP (all enables 0).
- D→E register:
  - Loads the decoded fields each cycle unless stalled.
  - Loads a bubble (all enables 0, ALUFunc 000) when FlushE_int = PCSrcE.
- E→W register:
  - Loads RegWE_E every cycle.
  - Loads 0 while a BNN op is still busy (result not yet valid).
- PCSrcE = BranchE & (zero XOR funct3E[0]).
- On PCSrcE:
  - FlushD=1 in the same cycle.
  - E receives a bubble next cycle.
  - Taken-branch penalty is exactly 2 cycles.
- BNN FSM has states IDLE and BUSY, with a 4-bit counter.
  - IDLE→BUSY when an E-stage op has ExPath=1 and BNN_LATENCY>1; counter loads BNN_LATENCY-1.
  - In BUSY: StallFD=1, the E register holds, and the counter decrements.
  - BUSY→IDLE when the counter reaches 1. The E→W transfer of RegWE happens on that exit edge.
  - With BNN_LATENCY=1, no stall occurs.
- Branch and BNN are mutually exclusive in E, so simultaneous events cannot arise. If FlushD and StallFD are both asserted, flush wins.
- Reset (synchronous, any cycle, including mid-BUSY):
  - FSM returns to IDLE and the counter clears.
  - E and W registers become bubbles.
  - All registered outputs go to 0: RegWE_E, RegWE_W, OpBSrcE, ExPathE, ALUFuncE=000, PCSrcE.
  - RetiredCount resets to 0.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: RetiredCount increments on every cycle where the W stage holds a valid non-bubble instruction. This includes branches and stores. It wraps at 2^32-1 → 0.
- Undefined: RetiredCount is tied to 0 and the counter logic is not synthesised. The port remains present.

Test Plan:
- ADDI x1,x0,7 (0x00700093) in D, one clock:
  - D: ImmFormatD=00.
  - Next cycle: ALUFuncE=000, OpBSrcE=1, RegWE_E=1, ExPathE=0.
  - Following cycle: RegWE_W=1.
- SUB x4,x1,x2 (0x40208233): ALUFuncE=001, OpBSrcE=0, RegWE_E=1. Then ADD x3,x1,x2 (0x002081B3): ALUFuncE=000.
- BEQ x0,x0,+8 (0x00000463) in D, then zero=1 in E:
  - PCSrcE=1 and FlushD=1 that cycle.
  - Next cycle: RegWE_E=0.
  - Repeat with zero=0: PCSrcE=0 and no flush.
- Custom-0 op (0x0020808B) with BNN_LATENCY=3:
  - StallFD=1 for exactly 2 cycles.
  - RegWE_W=1 exactly once, 3 cycles after entry into E.
  - Repeat with BNN_LATENCY=1: no stall.
- Reset asserted on the first BUSY cycle: next edge StallFD=0, RegWE_E=0, RegWE_W=0, and RetiredCount=0.
- Opcode 0x0000007F: IllegalD=1, and all E-stage enables stay 0. With PIPE_PERF_CNT_EN, RetiredCount does not increment for it, and does increment after three back-to-back ADDIs to 3.
